// File: rtl/alien_fleet_if.sv
// Missile-hit request/report bundle between a shooter (master) and the alien fleet (slave).
interface alien_fleet_if;
    logic       hit_valid;
    logic [9:0] hit_x;
    logic [9:0] hit_y;
    logic       hit_ready;
    logic       hit_ack;
    logic       hit_miss;
    logic [5:0] killed_idx;

    modport master (
        output hit_valid, hit_x, hit_y,
        input  hit_ready, hit_ack, hit_miss, killed_idx
    );

    modport slave (
        input  hit_valid, hit_x, hit_y,
        output hit_ready, hit_ack, hit_miss, killed_idx
    );
endinterface

// File: rtl/alien_fleet.sv
// 4x9 alien fleet: frame-paced marching/dropping plus a serial hit scanner over all 36 aliens.
// Optional feature macro ALIEN_SPEEDUP_EN halves the step period once 9 or fewer aliens remain.
module alien_fleet #(
    parameter int STEP_PERIOD = 8,
    parameter int STEP_X      = 4,
    parameter int STEP_Y      = 10,
    parameter int X_MIN       = 10,
    parameter int X_MAX       = 630,
    parameter int Y_LIMIT     = 400,
    parameter int X_START     = 20,
    parameter int Y_START     = 40
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frameTick,
    input  logic                restart,
    alien_fleet_if.slave        hit,
    output logic [9:0]          xAlien,
    output logic [9:0]          yAlien,
    output logic [35:0]         alive,
    output logic                allDead,
    output logic                reachedBottom
);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    localparam logic [15:0] PERIOD_FULL = 16'(STEP_PERIOD);
    localparam logic [15:0] PERIOD_FAST = ((STEP_PERIOD >> 1) < 1) ? 16'd1 : 16'(STEP_PERIOD >> 1);

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [1:0]  row_q, row_d;
    logic [3:0]  col_q, col_d;
    logic [9:0]  hx_q, hx_d, hy_q, hy_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        dir_left_q, dir_left_d;
    logic [35:0] alive_q, alive_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pending_q, pending_d;
    logic        ack_q, ack_d, miss_q, miss_d;
    logic [5:0]  kidx_q, kidx_d;
    logic        bottom_q, bottom_d;

    logic [15:0] period_s;
    logic [11:0] lx_s, ly_s, hx_s, hy_s, x_ext_s;
    logic        match_s, step_now_s, frozen_s, period_done_s, all_dead_s;

`ifdef ALIEN_SPEEDUP_EN
    function automatic logic [5:0] count_alive(input logic [35:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int k = 0; k < 36; k++) begin
            n = n + {5'd0, v[k]};
        end
        return n;
    endfunction

    assign period_s = (count_alive(alive_q) <= 6'd9) ? PERIOD_FAST : PERIOD_FULL;
`else
    assign period_s = PERIOD_FULL;
`endif

    // Extended to 12 bits so the box and edge compares never wrap.
    assign x_ext_s    = {2'b00, x_q};
    assign lx_s       = x_ext_s + 12'(col_q) * 12'd40;
    assign ly_s       = {2'b00, y_q} + 12'(row_q) * 12'd20;
    assign hx_s       = {2'b00, hx_q};
    assign hy_s       = {2'b00, hy_q};
    assign match_s    = alive_q[idx_q] && (hx_s > lx_s) && (hx_s < lx_s + 12'd20)
                        && (hy_s > ly_s) && (hy_s < ly_s + 12'd10);
    assign all_dead_s = (alive_q == 36'd0);
    assign frozen_s   = all_dead_s || bottom_q;
    assign step_now_s = (state_q == IDLE) && pending_q;

    // Next-state logic: frame pacing, fleet motion and the hit-scan FSM.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        row_d         = row_q;
        col_d         = col_q;
        hx_d          = hx_q;
        hy_d          = hy_q;
        x_d           = x_q;
        y_d           = y_q;
        dir_left_d    = dir_left_q;
        alive_d       = alive_q;
        cnt_d         = cnt_q;
        ack_d         = 1'b0;
        miss_d        = 1'b0;
        kidx_d        = kidx_q;
        period_done_s = 1'b0;

        if (frameTick) begin
            if (cnt_q + 16'd1 >= period_s) begin
                cnt_d         = 16'd0;
                period_done_s = 1'b1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
        pending_d = (pending_q && !step_now_s) || period_done_s;

        if (step_now_s && !frozen_s) begin
            if (!dir_left_q) begin
                if (x_ext_s + 12'(STEP_X) + 12'd340 > 12'(X_MAX)) begin
                    y_d        = y_q + 10'(STEP_Y);
                    dir_left_d = 1'b1;
                end else begin
                    x_d = x_q + 10'(STEP_X);
                end
            end else begin
                if (x_ext_s < 12'(X_MIN) + 12'(STEP_X)) begin
                    y_d        = y_q + 10'(STEP_Y);
                    dir_left_d = 1'b0;
                end else begin
                    x_d = x_q - 10'(STEP_X);
                end
            end
        end else begin
            x_d = x_q;
        end

        case (state_q)
            IDLE: begin
                if (hit.hit_valid) begin
                    hx_d    = hit.hit_x;
                    hy_d    = hit.hit_y;
                    idx_d   = 6'd0;
                    row_d   = 2'd0;
                    col_d   = 4'd0;
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (match_s) begin
                    alive_d[idx_q] = 1'b0;
                    ack_d          = 1'b1;
                    kidx_d         = idx_q;
                    state_d        = IDLE;
                end else if (idx_q == 6'd35) begin
                    miss_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 6'd1;
                    if (col_q == 4'd8) begin
                        col_d = 4'd0;
                        row_d = row_q + 2'd1;
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        bottom_d = bottom_q || ({2'b00, y_q} + 12'd70 >= 12'(Y_LIMIT));
    end

    // State register; restart returns everything to the reset state synchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;       idx_q <= 6'd0;       row_q <= 2'd0;   col_q <= 4'd0;
            hx_q <= 10'd0;         hy_q <= 10'd0;
            x_q <= 10'(X_START);   y_q <= 10'(Y_START); dir_left_q <= 1'b0;
            alive_q <= {36{1'b1}}; cnt_q <= 16'd0;      pending_q <= 1'b0;
            ack_q <= 1'b0;         miss_q <= 1'b0;      kidx_q <= 6'd0;  bottom_q <= 1'b0;
        end else if (restart) begin
            state_q <= IDLE;       idx_q <= 6'd0;       row_q <= 2'd0;   col_q <= 4'd0;
            hx_q <= 10'd0;         hy_q <= 10'd0;
            x_q <= 10'(X_START);   y_q <= 10'(Y_START); dir_left_q <= 1'b0;
            alive_q <= {36{1'b1}}; cnt_q <= 16'd0;      pending_q <= 1'b0;
            ack_q <= 1'b0;         miss_q <= 1'b0;      kidx_q <= 6'd0;  bottom_q <= 1'b0;
        end else begin
            state_q <= state_d;    idx_q <= idx_d;      row_q <= row_d;  col_q <= col_d;
            hx_q <= hx_d;          hy_q <= hy_d;
            x_q <= x_d;            y_q <= y_d;          dir_left_q <= dir_left_d;
            alive_q <= alive_d;    cnt_q <= cnt_d;      pending_q <= pending_d;
            ack_q <= ack_d;        miss_q <= miss_d;    kidx_q <= kidx_d; bottom_q <= bottom_d;
        end
    end

    assign hit.hit_ready  = (state_q == IDLE);
    assign hit.hit_ack    = ack_q;
    assign hit.hit_miss   = miss_q;
    assign hit.killed_idx = kidx_q;
    assign xAlien         = x_q;
    assign yAlien         = y_q;
    assign alive          = alive_q;
    assign allDead        = all_dead_s;
    assign reachedBottom  = bottom_q;

endmodule

// File: doc/alien_fleet.md
ALIEN_FLEET -- requirements
Module: alien_fleet

Interface
REQ-001 SHALL have parameter STEP_PERIOD, 8, frames between fleet steps.
REQ-002 SHALL have parameter STEP_X, 4, horizontal step in pixels.
REQ-003 SHALL have parameter STEP_Y, 10, vertical drop in pixels at an edge.
REQ-004 SHALL have parameter X_MIN, 10, leftmost allowed xAlien.
REQ-005 SHALL have parameter X_MAX, 630, rightmost allowed fleet pixel; fleet width is 340.
REQ-006 SHALL have parameter Y_LIMIT, 400, bottom line for the fleet.
REQ-007 SHALL have parameters X_START, 20, and Y_START, 40, initial fleet origin.
REQ-008 SHALL have port clk, input, 1, the single clock.
REQ-009 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port frameTick, input, 1, one-cycle pulse per video frame.
REQ-011 SHALL have port restart, input, 1, synchronous return to the reset state.
REQ-012 SHALL have ports hit_valid, input, 1, hit_x, input, 10, and hit_y, input, 10, a missile position request.
REQ-013 SHALL have port hit_ready, output, 1, high when a hit request can be accepted.
REQ-014 SHALL have ports hit_ack, output, 1, and killed_idx, output, 6, a one-cycle kill report.
REQ-015 SHALL have port hit_miss, output, 1, a one-cycle no-match report.
REQ-016 SHALL have ports xAlien, output, 10, yAlien, output, 10, and alive, output, 36, feeding the fleet renderer.
REQ-017 SHALL have ports allDead, output, 1, and reachedBottom, output, 1, as game status.

Function
REQ-018 Alien k=9i+j (i 0..3, j 0..8) SHALL occupy xAlien+40j < x < xAlien+40j+20 and yAlien+20i < y < yAlien+20i+10, both strict.
REQ-019 The FSM SHALL have states IDLE and SCAN; hit_ready SHALL be 1 only in IDLE.
REQ-020 In IDLE with hit_valid=1, the block SHALL latch hit_x and hit_y, set idx=0 and enter SCAN.
REQ-021 In SCAN, each cycle SHALL evaluate index idx against the latched position and the current fleet position; a match requires alive[idx]=1.
REQ-022 On a match, the block SHALL clear alive[idx], pulse hit_ack, set killed_idx=idx and return to IDLE; the ack appears idx+1 cycles after acceptance.
REQ-023 With no match through idx=35, the block SHALL pulse hit_miss 36 cycles after acceptance and return to IDLE.
REQ-024 Each frameTick SHALL increment the frame counter; when the count reaches the period, the counter SHALL clear and a step SHALL become pending.
REQ-025 A pending step SHALL execute in the next IDLE cycle; a step arising during SCAN SHALL be deferred until the return to IDLE, and it SHALL not be lost or doubled.
REQ-026 Moving right, if xAlien+STEP_X+340 > X_MAX, the step SHALL instead add STEP_Y to yAlien and reverse direction; otherwise it SHALL add STEP_X to xAlien.
REQ-027 Moving left, if xAlien-STEP_X < X_MIN, the step SHALL instead add STEP_Y to yAlien and reverse direction; otherwise it SHALL subtract STEP_X from xAlien.
REQ-028 All arithmetic SHALL be at least 11 bits wide so that no comparison wraps.
REQ-029 reachedBottom SHALL become 1 when yAlien+70 >= Y_LIMIT and SHALL stay 1 until reset or restart.
REQ-030 allDead SHALL equal (alive==0); while allDead or reachedBottom is 1, the fleet SHALL not move.
REQ-031 A hit request received while allDead=1 SHALL still be accepted and SHALL end with hit_miss.

Reset
REQ-032 On rst_n low or restart high, the block SHALL set xAlien=X_START, yAlien=Y_START, direction right, alive all ones, and the counter to 0.
REQ-033 On rst_n low or restart high, the block SHALL clear pending, hit_ack, hit_miss, killed_idx and reachedBottom, set state to IDLE and hit_ready=1.
REQ-034 If reset or restart occurs mid-SCAN, the block SHALL abandon the scan with no ack, no miss and no alive change.

Configuration
REQ-035 With ALIEN_SPEEDUP_EN defined, the step period SHALL be STEP_PERIOD>>1 (minimum 1) while 9 or fewer aliens are alive; without the macro, the period SHALL always be STEP_PERIOD.

Verification
REQ-036 Release reset -> xAlien=20, yAlien=40, alive=36'hFFFFFFFFF, hit_ready=1.
REQ-037 Apply 8 frameTicks -> xAlien=24; after 67 steps xAlien=288, and the next step gives yAlien=50, xAlien=288, direction left.
REQ-038 Hit at (xAlien+45, yAlien+25) -> hit_ack 11 cycles after acceptance, killed_idx=10, alive[10]=0; repeating the same hit gives hit_miss at 36 cycles.
REQ-039 Hit at (xAlien+20, yAlien+5) on the strict boundary -> hit_miss, alive unchanged.
REQ-040 frameTick completing a period during SCAN -> the move is applied exactly once, in the first IDLE cycle after the ack.
REQ-041 Kill all 36 aliens -> allDead=1 and xAlien frozen; with ALIEN_SPEEDUP_EN and 9 alive, steps occur every 4 frames.
